mc_ctrl: RTL and testbench

Multicycle control unit for the MIPS core. It replaces the single-cycle "pc increments every clock" sequencing with a Moore state machine that drives a shared datapath: one instruction/data memory, the instruction register, the register file, the ALU and the program counter. Instructions take 3–5 cycles. The block also keeps a retired-instruction counter for bring-up and performance checks.

---
 rtl/mc_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_mc_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl
// Description : Multicycle control unit for the MIPS core. A Moore state
//               machine sequences the shared datapath (unified memory, IR,
//               register file, ALU, PC) through 3-5 cycles per instruction
//               and counts retired instructions.
// Config      : MC_CTRL_JUMP_EN - when defined, opcode 000010 (j) executes
//               through the JUMP state; when undefined it decodes as illegal.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               op, funct, zero          - IR opcode/function fields, ALU zero
//               pc_en, iord, mem_write,
//               ir_write, reg_write,
//               reg_dst, mem_to_reg,
//               alu_src_a, alu_src_b,
//               pc_src, alu_ctl          - datapath controls
//               state                    - current state (debug)
//               illegal                  - pulse on unsupported opcode decode
//               retired                  - completed-instruction counter
// Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             pc_en,
    output logic             iord,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_src,
    output logic [2:0]       alu_ctl,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    localparam logic [3:0] c_fetch  = 4'd0;
    localparam logic [3:0] c_decode = 4'd1;
    localparam logic [3:0] c_memadr = 4'd2;
    localparam logic [3:0] c_memrd  = 4'd3;
    localparam logic [3:0] c_memwb  = 4'd4;
    localparam logic [3:0] c_memwr  = 4'd5;
    localparam logic [3:0] c_exec   = 4'd6;
    localparam logic [3:0] c_aluwb  = 4'd7;
    localparam logic [3:0] c_branch = 4'd8;
    localparam logic [3:0] c_addiex = 4'd9;
    localparam logic [3:0] c_addiwb = 4'd10;
`ifdef MC_CTRL_JUMP_EN
    localparam logic [3:0] c_jump   = 4'd11;
    localparam logic [5:0] c_op_j   = 6'b000010;
`endif

    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_addi  = 6'b001000;

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic [CNT_W-1:0] r_retired;
    logic             w_pc_write;
    logic             w_branch;
    logic             w_retire;

    always_comb begin
        w_next     = c_fetch;
        w_pc_write = 1'b0;
        w_branch   = 1'b0;
        w_retire   = 1'b0;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        alu_ctl    = 3'b010;
        illegal    = 1'b0;
        case (r_state)
            c_fetch: begin
                ir_write   = 1'b1;
                alu_src_b  = 2'b01;
                w_pc_write = 1'b1;
                w_next     = c_decode;
            end
            c_decode: begin
                // PC + (imm << 2) lands in ALUOut for a possible beq
                alu_src_b = 2'b11;
                case (op)
                    c_op_lw, c_op_sw: w_next = c_memadr;
                    c_op_rtype:       w_next = c_exec;
                    c_op_beq:         w_next = c_branch;
                    c_op_addi:        w_next = c_addiex;
`ifdef MC_CTRL_JUMP_EN
                    c_op_j:           w_next = c_jump;
`endif
                    default: begin
                        illegal = 1'b1;
                        w_next  = c_fetch;
                    end
                endcase
            end
            c_memadr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = (op == c_op_lw) ? c_memrd : c_memwr;
            end
            c_memrd: begin
                iord   = 1'b1;
                w_next = c_memwb;
            end
            c_memwb: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                w_retire   = 1'b1;
            end
            c_memwr: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                w_retire  = 1'b1;
            end
            c_exec: begin
                alu_src_a = 1'b1;
                case (funct)
                    6'b100010: alu_ctl = 3'b110;
                    6'b100100: alu_ctl = 3'b000;
                    6'b100101: alu_ctl = 3'b001;
                    6'b101010: alu_ctl = 3'b111;
                    default:   alu_ctl = 3'b010;
                endcase
                w_next = c_aluwb;
            end
            c_aluwb: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                w_retire  = 1'b1;
            end
            c_branch: begin
                alu_src_a = 1'b1;
                alu_ctl   = 3'b110;
                w_branch  = 1'b1;
                pc_src    = 2'b01;
                w_retire  = 1'b1;
            end
            c_addiex: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = c_addiwb;
            end
            c_addiwb: begin
                reg_write = 1'b1;
                w_retire  = 1'b1;
            end
`ifdef MC_CTRL_JUMP_EN
            c_jump: begin
                pc_src     = 2'b10;
                w_pc_write = 1'b1;
                w_retire   = 1'b1;
            end
`endif
            default: begin
                // unused encodings: everything low, recover to FETCH
                alu_ctl = 3'b000;
                w_next  = c_fetch;
            end
        endcase
    end

    assign pc_en   = w_pc_write | (w_branch & zero);
    assign state   = r_state;
    assign retired = r_retired;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_fetch;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_ctrl
// Description : Self-checking bench for mc_ctrl. A driver issues directed and
//               random instructions and queues the expected per-cycle control
//               outputs; a monitor pops and compares on every falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [5:0]       op = 6'd0;
    logic [5:0]       funct = 6'd0;
    logic             zero = 1'b0;
    logic             pc_en, iord, mem_write, ir_write, reg_write, reg_dst;
    logic             mem_to_reg, alu_src_a, illegal;
    logic [1:0]       alu_src_b, pc_src;
    logic [2:0]       alu_ctl;
    logic [3:0]       state;
    logic [CNT_W-1:0] retired;

    mc_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
        .pc_en(pc_en), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
        .alu_ctl(alu_ctl), .state(state), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]       state;
        logic             pc_en, iord, mem_write, ir_write;
        logic             reg_write, reg_dst, mem_to_reg, alu_src_a;
        logic [1:0]       alu_src_b, pc_src;
        logic [2:0]       alu_ctl;
        logic             illegal;
        logic [CNT_W-1:0] retired;
    } obs_t;

    obs_t             exp_q[$];
    int               checks = 0;
    int               failures = 0;
    logic [CNT_W-1:0] model_retired = '0;
    bit               mon_en = 1'b0;

    // Instruction path: hex digits are the visited states, in order.
    task automatic path_for(input logic [5:0] o, output logic [19:0] s, output int n);
        case (o)
            6'b100011: begin s = 20'h01234; n = 5; end
            6'b101011: begin s = 20'h01250; n = 4; end
            6'b000000: begin s = 20'h01670; n = 4; end
            6'b000100: begin s = 20'h01800; n = 3; end
            6'b001000: begin s = 20'h019A0; n = 4; end
`ifdef MC_CTRL_JUMP_EN
            6'b000010: begin s = 20'h01B00; n = 3; end
`endif
            default:   begin s = 20'h01000; n = 2; end
        endcase
    endtask

    function automatic logic [2:0] funct_ctl(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic obs_t expect_cycle(input logic [3:0] st, input logic [5:0] f,
                                          input logic z, input bit ill,
                                          input logic [CNT_W-1:0] r);
        obs_t e;
        e = '0;
        e.state   = st;
        e.alu_ctl = 3'b010;
        e.retired = r;
        case (st)
            4'd0:  begin e.ir_write = 1'b1; e.alu_src_b = 2'b01; e.pc_en = 1'b1; end
            4'd1:  begin e.alu_src_b = 2'b11; e.illegal = ill; end
            4'd2:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            4'd3:  begin e.iord = 1'b1; end
            4'd4:  begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; end
            4'd5:  begin e.iord = 1'b1; e.mem_write = 1'b1; end
            4'd6:  begin e.alu_src_a = 1'b1; e.alu_ctl = funct_ctl(f); end
            4'd7:  begin e.reg_dst = 1'b1; e.reg_write = 1'b1; end
            4'd8:  begin e.alu_src_a = 1'b1; e.alu_ctl = 3'b110; e.pc_src = 2'b01; e.pc_en = z; end
            4'd9:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            4'd10: begin e.reg_write = 1'b1; end
            4'd11: begin e.pc_src = 2'b10; e.pc_en = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Called at edge+1 with the DUT in FETCH; returns at edge+1 of the next FETCH.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input bit rst_mid);
        logic [19:0] s;
        int          n;
        op = o; funct = f; zero = z;
        path_for(o, s, n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(expect_cycle(s[19-4*i -: 4], f, z, (n == 2), model_retired));
        end
        if (!rst_mid) begin
            repeat (n) @(posedge clk);
            #1;
            if (n != 2) model_retired = model_retired + 1;
        end else begin
            // reset lands on the edge that would leave the last state
            repeat (n - 1) @(posedge clk);
            #1 rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
            model_retired = '0;
        end
    endtask

    always @(negedge clk) begin
        obs_t act;
        obs_t e;
        if (mon_en) begin
            act = {state, pc_en, iord, mem_write, ir_write, reg_write, reg_dst,
                   mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_ctl, illegal, retired};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_underflow actual_state=%0d expected=none", state);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    failures++;
                    $display("FAIL cycle state=%0d actual=%h expected=%h", e.state, act, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ro, rf;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_ir_write", 32'(ir_write), 32'd1);
        chk("reset_pc_en", 32'(pc_en), 32'd1);
        chk("reset_mem_write", 32'(mem_write), 32'd0);
        chk("reset_illegal", 32'(illegal), 32'd0);
        chk("reset_retired", retired, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;

        // directed
        run_instr(6'b100011, 6'd0,      1'b0, 1'b0); // lw
        run_instr(6'b101011, 6'd0,      1'b0, 1'b0); // sw
        run_instr(6'b000000, 6'b100010, 1'b0, 1'b0); // sub
        run_instr(6'b000100, 6'd0,      1'b1, 1'b0); // beq taken
        run_instr(6'b000100, 6'd0,      1'b0, 1'b0); // beq not taken
        run_instr(6'b111111, 6'd0,      1'b0, 1'b0); // illegal
        run_instr(6'b000010, 6'd0,      1'b0, 1'b0); // j
        run_instr(6'b001000, 6'd0,      1'b0, 1'b0); // addi
        run_instr(6'b101011, 6'd0,      1'b0, 1'b1); // sw, reset in MEMWR
        run_instr(6'b000000, 6'b101010, 1'b1, 1'b0); // slt after reset

        // random
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 7))
                0: ro = 6'b100011;
                1: ro = 6'b101011;
                2: ro = 6'b000000;
                3: ro = 6'b000100;
                4: ro = 6'b001000;
                5: ro = 6'b000010;
                6: ro = 6'($urandom);
                default: ro = 6'b111111;
            endcase
            case ($urandom_range(0, 5))
                0: rf = 6'b100000;
                1: rf = 6'b100010;
                2: rf = 6'b100100;
                3: rf = 6'b100101;
                4: rf = 6'b101010;
                default: rf = 6'($urandom);
            endcase
            run_instr(ro, rf, 1'($urandom), (ro == 6'b101011) && ($urandom_range(0, 9) == 0));
        end

        mon_en = 1'b0;
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
